// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with a PC-tagged prefetch queue
// Owns the fetch PC, issues word fetches over req/ack and hands buffered words to decode.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;

    logic [31:0]   entry_instr_q [DEPTH];
    logic [31:0]   entry_pc_q    [DEPTH];

    logic          push;
    logic          pop;
    logic [AW:0]   count_next;
    logic [31:0]   target_pc;

    always_comb begin
        target_pc  = redirect_pc & ~32'h3;
        // A redirect voids both the returning word and any pop in the same cycle.
        pop        = valid_q && out_ready && !redirect;
        push       = (state_q == ST_REQ) && imem_ack && !redirect;
        count_next = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        count_d    = count_next;
        head_d     = head_q;
        tail_d     = tail_q;

        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end

        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = target_pc;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                    addr_d  = target_pc;
                end
                ST_REQ: begin
                    // Never move the address mid-handshake; the stale word is dropped later.
                    if (imem_ack) begin
                        addr_d = target_pc;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    state_d = ST_DISCARD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_next < FULL_COUNT) begin
                        state_d = ST_REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (count_next < FULL_COUNT) begin
                            addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        state_d = ST_REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        req_d   = (state_d != ST_IDLE);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entry_instr_q[tail_q] <= imem_data;
            entry_pc_q[tail_q]    <= addr_q;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = valid_q;
    assign out_instr = valid_q ? entry_instr_q[head_q] : 32'h0;
    assign out_pc    = valid_q ? entry_pc_q[head_q] : 32'h0;

endmodule
